// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the FSM, the datapath top and the port interface.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int         DIV_ITERS  = 8;
  localparam logic [7:0] DIV_ZERO_Q = 8'hFF;

endpackage

// File: rtl/divider_if.sv
// Operand/result bundle between the calculator and the divider.
// master drives the start and operands, slave returns results.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
);

  logic             enter;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output enter, A, B,
    input  Q, R, done, busy, err
  );

  modport slave (
    input  enter, A, B,
    output Q, R, done, busy, err
  );

endinterface

// File: rtl/divide_fsm.sv
// Divider control: start edge detect, IDLE/RUN/DONE sequencing
// and the iteration counter.
module divide_fsm
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enter,
  input  logic b_zero,
  output logic load,
  output logic zero,
  output logic step,
  output logic capture,
  output logic busy,
  output logic done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter_q;
  logic          busy_q, done_q;
  logic          start;

  assign start = enter & ~enter_q;

  // busy/done are registered decodes of the next state, so glitch-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = b_zero ? DONE : RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = (state_q == IDLE) & start & ~b_zero;
    zero    = (state_q == IDLE) & start &  b_zero;
    step    = (state_q == RUN);
    capture = (state_q == RUN) & (cnt_q == LAST);
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Control lives in divide_fsm; this file holds the shift/subtract path.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  logic             load, zero, step, capture;
  logic             busy, done;
  logic             b_zero;

  logic [WIDTH:0]   rem_q, rem_d, rem_sh;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             err_q;
  logic             ge;

  assign b_zero = (bus.B == '0);

  divide_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .enter   (bus.enter),
    .b_zero  (b_zero),
    .load    (load),
    .zero    (zero),
    .step    (step),
    .capture (capture),
    .busy    (busy),
    .done    (done)
  );

  // dvd_q shifts out dividend bits and shifts in quotient bits
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, b_q});
    rem_d  = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
    dvd_d  = {dvd_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      dvd_q <= '0;
      b_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (load) begin
        dvd_q <= bus.A;
        b_q   <= bus.B;
        rem_q <= '0;
      end else if (step) begin
        dvd_q <= dvd_d;
        rem_q <= rem_d;
      end
      if (capture) begin
        q_q   <= dvd_d;
        r_q   <= rem_d[WIDTH-1:0];
        err_q <= 1'b0;
      end else if (zero) begin
        q_q   <= '1;
        r_q   <= bus.A;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.err  = err_q;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
